// File: rtl/nn_layer_sequencer_if.sv
// Request, datapath-control and result signals of the layer sequencer.
// The master modport is the sequencer side; the slave modport is the source/datapath side.
interface nn_layer_sequencer_if #(
  parameter int CW = 16
);
  logic          req;
  logic [7:0]    label;
  logic          clr_cnt;
  logic          dp_ready;
  logic [7:0]    dp_test_out;
  logic          dp_start;
  logic          dp_hidden;
  logic          dp_ld1;
  logic          dp_ld2;
  logic [1:0]    dp_state;
  logic          busy;
  logic          done;
  logic [7:0]    class_out;
  logic          correct;
  logic          timeout;
  logic [CW-1:0] correct_cnt;
  logic [CW-1:0] total_cnt;

  modport master (
    input  req, label, clr_cnt, dp_ready, dp_test_out,
    output dp_start, dp_hidden, dp_ld1, dp_ld2, dp_state,
    output busy, done, class_out, correct, timeout, correct_cnt, total_cnt
  );

  modport slave (
    output req, label, clr_cnt, dp_ready, dp_test_out,
    input  dp_start, dp_hidden, dp_ld1, dp_ld2, dp_state,
    input  busy, done, class_out, correct, timeout, correct_cnt, total_cnt
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Steps one classification through hidden-1, hidden-2 and output layers; done is high in the
// 15th cycle after req when dp_ready is always high. req is ignored while busy; WAIT aborts after TIMEOUT cycles.
module nn_layer_sequencer #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  nn_layer_sequencer_if.master bus
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [WW-1:0] SETTLE_W = WW'(SETTLE);
  localparam logic [WW-1:0] TMO_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, H1_START, H1_WAIT, H1_LOAD, H2_START, H2_WAIT, H2_LOAD, O_START, O_WAIT, O_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [7:0]    label_q, label_d;
  logic [7:0]    class_q, class_d;
  logic          correct_q, correct_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] total_q, total_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          start_q, start_d;
  logic          hidden_q, hidden_d;
  logic          ld1_q, ld1_d;
  logic          ld2_q, ld2_d;
  logic [1:0]    dps_q, dps_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rdy_ok;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Ready seen during the first SETTLE wait cycles may be left over from the previous layer.
  assign rdy_ok = bus.dp_ready && (wcnt_q >= SETTLE_W);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = '0;
    label_d   = label_q;
    class_d   = class_q;
    correct_d = correct_q;
    timeout_d = timeout_q;
    total_d   = total_q;
    ccnt_d    = ccnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d   = H1_START;
          label_d   = bus.label;
          timeout_d = 1'b0;
        end
      end
      H1_START: state_d = H1_WAIT;
      H2_START: state_d = H2_WAIT;
      O_START:  state_d = O_WAIT;
      H1_WAIT, H2_WAIT, O_WAIT: begin
        if (rdy_ok) begin
          if (state_q == H1_WAIT) begin
            state_d = H1_LOAD;
          end else if (state_q == H2_WAIT) begin
            state_d = H2_LOAD;
          end else begin
            state_d   = O_DONE;
            class_d   = bus.dp_test_out;
            correct_d = (bus.dp_test_out == label_q);
          end
        end else if (wcnt_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      H1_LOAD: state_d = H2_START;
      H2_LOAD: state_d = O_START;
      O_DONE: begin
        state_d = IDLE;
        total_d = sat_inc(total_q);
        if (correct_q) ccnt_d = sat_inc(ccnt_q);
      end
      default: state_d = IDLE;
    endcase
    if (bus.clr_cnt) begin
      total_d = '0;
      ccnt_d  = '0;
    end

    // Outputs are decoded from the next state so they appear registered with the state itself.
    start_d  = (state_d == H1_START) || (state_d == H2_START) || (state_d == O_START);
    ld1_d    = (state_d == H1_LOAD);
    ld2_d    = (state_d == H2_LOAD);
    done_d   = (state_d == O_DONE);
    busy_d   = (state_d != IDLE);
    dps_d    = 2'b00;
    hidden_d = 1'b0;
    case (state_d)
      H1_START, H1_WAIT, H1_LOAD: begin dps_d = 2'b00; hidden_d = 1'b1; end
      H2_START, H2_WAIT, H2_LOAD: begin dps_d = 2'b01; hidden_d = 1'b1; end
      O_START, O_WAIT, O_DONE:    begin dps_d = 2'b10; hidden_d = 1'b0; end
      default:                    begin dps_d = 2'b00; hidden_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      label_q   <= '0;
      class_q   <= '0;
      correct_q <= 1'b0;
      timeout_q <= 1'b0;
      total_q   <= '0;
      ccnt_q    <= '0;
      start_q   <= 1'b0;
      hidden_q  <= 1'b0;
      ld1_q     <= 1'b0;
      ld2_q     <= 1'b0;
      dps_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      label_q   <= label_d;
      class_q   <= class_d;
      correct_q <= correct_d;
      timeout_q <= timeout_d;
      total_q   <= total_d;
      ccnt_q    <= ccnt_d;
      start_q   <= start_d;
      hidden_q  <= hidden_d;
      ld1_q     <= ld1_d;
      ld2_q     <= ld2_d;
      dps_q     <= dps_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.dp_start    = start_q;
  assign bus.dp_hidden   = hidden_q;
  assign bus.dp_ld1      = ld1_q;
  assign bus.dp_ld2      = ld2_q;
  assign bus.dp_state    = dps_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.class_out   = class_q;
  assign bus.correct     = correct_q;
  assign bus.timeout     = timeout_q;
  assign bus.correct_cnt = ccnt_q;
  assign bus.total_cnt   = total_q;

endmodule
